// File: rtl/uart_ahb_pkg.sv
// Shared definitions for the UART-to-AHB command bridge: FSM states, opcode and
// response bytes, AHB transfer types and the fixed 32-bit bus widths.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package uart_ahb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    AHB_A = 3'd3,
    AHB_D = 3'd4,
    RESP  = 3'd5
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO  = 8'h54;  // 'T'

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int unsigned RESP_BYTES = 5;

endpackage

// File: rtl/uart_ahb_tx_ser.sv
// Response serialiser: loads up to five bytes (MSB first) and presents them one
// at a time on a valid/ready handshake; done_o pulses as the last byte leaves.
module uart_ahb_tx_ser
  import uart_ahb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [8*RESP_BYTES-1:0]   bytes_i,
  input  logic [2:0]                len_i,
  input  logic                      tx_ready_i,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  output logic                      done_o
);

  logic [8*(RESP_BYTES-1)-1:0] buf_q;
  logic [2:0]                  left_q;
  logic                        valid_q;
  logic [7:0]                  data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      data_q  <= bytes_i[8*RESP_BYTES-1 -: 8];
      buf_q   <= bytes_i[8*(RESP_BYTES-1)-1:0];
      left_q  <= len_i;
      valid_q <= (len_i != 3'd0);
    end else if (valid_q && tx_ready_i) begin
      if (left_q == 3'd1) begin
        valid_q <= 1'b0;
        left_q  <= '0;
      end else begin
        data_q  <= buf_q[8*(RESP_BYTES-1)-1 -: 8];
        buf_q   <= {buf_q[8*(RESP_BYTES-2)-1:0], 8'h00};
        left_q  <= left_q - 3'd1;
      end
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;
  assign done_o     = valid_q & tx_ready_i & (left_q == 3'd1);

endmodule

// File: rtl/uart_ahb_master.sv
// UART command frames ('W'/'R' + address [+ data]) turned into single AHB
// transfers with a short byte response. Optional idle timeout: UART_AHB_MASTER_TIMEOUT_EN.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module uart_ahb_master
  import uart_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [1:0]                 htrans,
  output logic [`AHB_ADDR_WIDTH-1:0] haddr,
  output logic                       hwrite,
  output logic [`AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                       hready,
  input  logic                       hresp,
  input  logic [`AHB_DATA_WIDTH-1:0] hrdata
);

  localparam int AW = `AHB_ADDR_WIDTH;
  localparam int DW = `AHB_DATA_WIDTH;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..2^24-1");
  end

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              rx_ready_q;
  logic [AW-1:0]     haddr_q;
  logic              hwrite_q;
  logic [DW-1:0]     hwdata_q;

  logic              rx_fire;
  logic              timeout_hit;
  logic              load;
  logic [8*RESP_BYTES-1:0] load_bytes;
  logic [2:0]        load_len;
  logic              tx_done;

  assign rx_fire = rx_valid & rx_ready_q;

`ifdef UART_AHB_MASTER_TIMEOUT_EN
  logic [23:0] idle_cnt_q;
  logic        in_frame;

  assign in_frame = (state_q == ADDR) || (state_q == DATA);

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_fire) idle_cnt_q <= '0;
    else                              idle_cnt_q <= idle_cnt_q + 24'd1;
  end

  assign timeout_hit = in_frame && !rx_fire && (idle_cnt_q == 24'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    load       = 1'b0;
    load_bytes = '0;
    load_len   = 3'd0;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_write_d = (rx_data == OP_WRITE);
            cnt_d      = 2'd0;
            state_d    = ADDR;
          end else begin
            load       = 1'b1;
            load_bytes = {RSP_BAD, 32'h0};
            load_len   = 3'd1;
            state_d    = RESP;
          end
        end
      end
      ADDR, DATA: begin
        if (rx_fire) begin
          if (state_q == ADDR) addr_d = {addr_q[AW-9:0], rx_data};
          else                 data_d = {data_q[DW-9:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = (state_q == ADDR && is_write_q) ? DATA : AHB_A;
          end
        end else if (timeout_hit) begin
          load       = 1'b1;
          load_bytes = {RSP_TMO, 32'h0};
          load_len   = 3'd1;
          state_d    = RESP;
        end
      end
      AHB_A: begin
        if (hready) state_d = AHB_D;
      end
      AHB_D: begin
        if (hready) begin
          load    = 1'b1;
          state_d = RESP;
          if (hresp) begin
            load_bytes = {RSP_ERR, 32'h0};
            load_len   = 3'd1;
          end else if (is_write_q) begin
            load_bytes = {RSP_OK, 32'h0};
            load_len   = 3'd1;
          end else begin
            load_bytes = {RSP_OK, hrdata};
            load_len   = 3'd5;
          end
        end
      end
      RESP: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments; the reset is synchronous,
  // so it is just the first branch of the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b0;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rx_ready_q <= (state_d == IDLE) || (state_d == ADDR) || (state_d == DATA);
      // Bus address/direction only change when a new transfer starts.
      if (state_d == AHB_A && state_q != AHB_A) begin
        haddr_q  <= addr_d;
        hwrite_q <= is_write_q;
      end
      if (state_q == AHB_A && hready) hwdata_q <= data_q;
    end
  end

  uart_ahb_tx_ser u_tx_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .bytes_i    (load_bytes),
    .len_i      (load_len),
    .tx_ready_i (tx_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .done_o     (tx_done)
  );

  assign rx_ready = rx_ready_q;
  assign htrans   = (state_q == AHB_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr    = haddr_q;
  assign hwrite   = hwrite_q;
  assign hwdata   = hwdata_q;

endmodule

// File: tb/tb_uart_ahb_master.sv
// Bench for uart_ahb_master: vector table of command frames, an AHB slave model
// with programmable wait states, and a scoreboard of expected response bytes.
module tb_uart_ahb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = 32'h0;

  always #5 clk = ~clk;

  uart_ahb_master #(.TIMEOUT_CYCLES(50)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .htrans   (htrans),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .hwdata   (hwdata),
    .hready   (hready),
    .hresp    (hresp),
    .hrdata   (hrdata)
  );

  typedef struct {
    logic [71:0] frame;    // bytes left-aligned, first byte in [71:64]
    int          n;
    logic [31:0] rdata;
    logic        err;
    int          await_c;  // hready-low cycles in the address phase
    int          dwait_c;  // hready-low cycles in the data phase
    int          stall_c;  // tx_ready-low cycles during the response
    logic        xfer;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [39:0] resp;     // left-aligned response bytes
    int          rlen;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          await_c;
    int          dwait_c;
  } ahb_exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  tx_q[$];
  ahb_exp_t    ahb_q[$];
  vec_t        vecs[8];

  logic [31:0] cur_rdata = 32'h0;
  logic        cur_err = 1'b0;
  int          stall_left = 0;
  int          nonseq_cnt = 0;
  bit          in_d = 1'b0;
  int          d_cnt = 0;
  ahb_exp_t    cur;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not seen / not expected", name);
  endtask

  // AHB slave model and tx scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      nonseq_cnt = 0;
      in_d       = 1'b0;
      d_cnt      = 0;
      hready     = 1'b1;
      tx_ready   = 1'b1;
      stall_left = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      hresp  = cur_err;
      hrdata = cur_rdata;
      if (htrans == 2'b10) begin
        if (ahb_q.size() == 0) begin
          fail_bound("ahb_unexpected");
          hready = 1'b1;
        end else begin
          cur = ahb_q[0];
          check("haddr", haddr, cur.addr);
          nonseq_cnt++;
          hready = (nonseq_cnt > cur.await_c);
          if (hready) begin
            check("hwrite", 32'(hwrite), 32'(cur.wr));
            check("rx_ready_busy", 32'(rx_ready), 32'h0);
            void'(ahb_q.pop_front());
            in_d       = 1'b1;
            d_cnt      = 0;
            nonseq_cnt = 0;
          end
        end
      end else if (in_d) begin
        check("htrans_data_phase", 32'(htrans), 32'h0);
        hready = (d_cnt >= cur.dwait_c);
        if (d_cnt == 0 && cur.wr) check("hwdata", hwdata, cur.wdata);
        d_cnt++;
        if (hready) in_d = 1'b0;
      end else begin
        hready = 1'b1;
      end

      tx_ready = (stall_left == 0);
      if (prev_valid && !prev_ready) begin
        check("tx_hold_valid", 32'(tx_valid), 32'h1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && !tx_ready) stall_left--;
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          fail_bound("tx_unexpected");
        end else begin
          logic [7:0] exp_b;
          exp_b = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(exp_b));
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) fail_bound("rx_accept_timeout");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (tx_q.size() == 0 && ahb_q.size() == 0 && rx_ready && !tx_valid) ok = 1'b1;
    end
    if (!ok) begin
      fail_bound("idle_timeout");
      tx_q.delete();
      ahb_q.delete();
    end
  endtask

  task automatic expect_ahb(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int aw, input int dw);
    ahb_exp_t e;
    e.addr    = a;
    e.wr      = w;
    e.wdata   = d;
    e.await_c = aw;
    e.dwait_c = dw;
    ahb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    cur_rdata  = v.rdata;
    cur_err    = v.err;
    stall_left = v.stall_c;
    if (v.xfer) expect_ahb(v.addr, v.wr, v.wdata, v.await_c, v.dwait_c);
    for (int i = 0; i < v.rlen; i++) tx_q.push_back(v.resp[39-8*i -: 8]);
    for (int i = 0; i < v.n; i++) send_byte(v.frame[71-8*i -: 8]);
    // The address phase must start the cycle right after the last frame byte.
    if (v.xfer) check("latency_htrans", 32'(htrans), 32'h2);
    check("rx_ready_after_frame", 32'(rx_ready), 32'h0);
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{frame:72'h57_00_00_10_00_DE_AD_BE_EF, n:9, rdata:32'h0, err:1'b0,
                await_c:0, dwait_c:0, stall_c:0, xfer:1'b1, addr:32'h0000_1000, wr:1'b1,
                wdata:32'hDEAD_BEEF, resp:40'h4B_00_00_00_00, rlen:1};
    vecs[1] = '{frame:72'h52_00_00_20_04_00_00_00_00, n:5, rdata:32'h1234_5678, err:1'b0,
                await_c:0, dwait_c:0, stall_c:0, xfer:1'b1, addr:32'h0000_2004, wr:1'b0,
                wdata:32'h0, resp:40'h4B_12_34_56_78, rlen:5};
    vecs[2] = '{frame:72'h57_A5_A5_00_04_01_02_03_04, n:9, rdata:32'h0, err:1'b1,
                await_c:5, dwait_c:0, stall_c:0, xfer:1'b1, addr:32'hA5A5_0004, wr:1'b1,
                wdata:32'h0102_0304, resp:40'h45_00_00_00_00, rlen:1};
    vecs[3] = '{frame:72'h00_00_00_00_00_00_00_00_00, n:1, rdata:32'h0, err:1'b0,
                await_c:0, dwait_c:0, stall_c:0, xfer:1'b0, addr:32'h0, wr:1'b0,
                wdata:32'h0, resp:40'h3F_00_00_00_00, rlen:1};
    vecs[4] = '{frame:72'h52_FF_FF_FF_FC_00_00_00_00, n:5, rdata:32'hCAFE_F00D, err:1'b0,
                await_c:0, dwait_c:0, stall_c:10, xfer:1'b1, addr:32'hFFFF_FFFC, wr:1'b0,
                wdata:32'h0, resp:40'h4B_CA_FE_F0_0D, rlen:5};
    vecs[5] = '{frame:72'h52_00_00_00_08_00_00_00_00, n:5, rdata:32'h1111_1111, err:1'b1,
                await_c:0, dwait_c:0, stall_c:0, xfer:1'b1, addr:32'h0000_0008, wr:1'b0,
                wdata:32'h0, resp:40'h45_00_00_00_00, rlen:1};
    vecs[6] = '{frame:72'h77_00_00_00_00_00_00_00_00, n:1, rdata:32'h0, err:1'b0,
                await_c:0, dwait_c:0, stall_c:0, xfer:1'b0, addr:32'h0, wr:1'b0,
                wdata:32'h0, resp:40'h3F_00_00_00_00, rlen:1};
    vecs[7] = '{frame:72'h52_80_00_00_00_00_00_00_00, n:5, rdata:32'h0000_0000, err:1'b0,
                await_c:0, dwait_c:3, stall_c:0, xfer:1'b1, addr:32'h8000_0000, wr:1'b0,
                wdata:32'h0, resp:40'h4B_00_00_00_00, rlen:5};

    // Reset values, then rx_ready rising one cycle after release.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", 32'(hwrite), 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rx_ready_after_release", 32'(rx_ready), 32'h1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // A byte presented while the bridge is busy waits until IDLE.
    cur_rdata = 32'h0BAD_F00D;
    cur_err   = 1'b0;
    expect_ahb(32'h0000_0040, 1'b0, 32'h0, 3, 0);
    tx_q.push_back(8'h4B); tx_q.push_back(8'h0B); tx_q.push_back(8'hAD);
    tx_q.push_back(8'hF0); tx_q.push_back(8'h0D); tx_q.push_back(8'h3F);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h00);
    wait_idle();
    check("haddr_hold", haddr, 32'h0000_0040);
    check("hwrite_hold", 32'(hwrite), 32'h0);

    // Partial frame left idle.
`ifdef UART_AHB_MASTER_TIMEOUT_EN
    tx_q.push_back(8'h54);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
`else
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    repeat (200) @(posedge clk);
    #1;
    check("no_timeout_rx_ready", 32'(rx_ready), 32'h1);
    check("no_timeout_tx_valid", 32'(tx_valid), 32'h0);
    cur_rdata = 32'h89AB_CDEF;
    expect_ahb(32'h0000_2004, 1'b0, 32'h0, 0, 0);
    tx_q.push_back(8'h4B); tx_q.push_back(8'h89); tx_q.push_back(8'hAB);
    tx_q.push_back(8'hCD); tx_q.push_back(8'hEF);
    send_byte(8'h20); send_byte(8'h04);
    wait_idle();
`endif

    // Reset during the data phase aborts silently.
    cur_err = 1'b0;
    expect_ahb(32'h0000_3000, 1'b1, 32'h55AA_55AA, 0, 1000);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hAA);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(posedge clk);
        #2;
        if (in_d) seen = 1'b1;
      end
      if (!seen) fail_bound("data_phase_not_reached");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_htrans", 32'(htrans), 32'h0);
    check("abort_tx_valid", 32'(tx_valid), 32'h0);
    check("abort_haddr", haddr, 32'h0);
    rst = 1'b0;
    ahb_q.delete();
    @(posedge clk);
    #1;
    check("abort_rx_ready", 32'(rx_ready), 32'h1);
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
